uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmitter among R requester registers in the I/O echo subsystem. It owns the selection input of the I/O register multiplexor: it picks a requester, holds the selection stable, fires the transmitter start strobe, waits for the transmit-done tick, and then acknowledges the requester. It sits between the I/O request registers and the UART TX/multiplexor pair.

## Interface
- R, 2, number of requesters; R ≥ 2
- T, 8, data width of each requester register (informational; sizes nothing here)
- N, 1, selection width; N ≥ ceil(log2(R))
- TO_CYCLES, 4096, watchdog limit in clk cycles (used only with ARB_TIMEOUT_EN); ≥ 2
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- req  input  R  per-requester "byte ready" level; bit i owns datain slot i of the multiplexor
- tx_done_tick  input  1  one-cycle pulse from UART TX: frame finished
- selection  output  N  registered multiplexor select
- tx_start  output  1  one-cycle start strobe to UART TX
- ack  output  R  one-hot, one-cycle "byte consumed" pulse to the granted requester
- busy  output  1  high in every state except IDLE
- timeout_err  output  1  one-cycle pulse on watchdog abort; constant 0 without ARB_TIMEOUT_EN

## Operation
- States: IDLE, START, WAIT, ACK. Reset → IDLE.
- Reset values: selection=0, tx_start=0, ack=0, busy=0, timeout_err=0, grant index=0, priority pointer=0, watchdog=0.
- IDLE: if req≠0, grant = first set bit of req scanning from pointer upward with wrap-around modulo R; register selection=grant; → START. If req=0 stay.
- START: tx_start=1 (Moore); → WAIT unconditionally.
- WAIT: hold selection; on tx_done_tick → ACK.
- ACK: ack[grant]=1 (Moore); pointer = grant+1, wrapping R-1 → 0; → IDLE.
- selection changes only on the IDLE→START edge; never takes values ≥ R.
- req deasserted after the grant: ignored, sequence completes and ack still issues.
- tx_done_tick in IDLE, START or ACK: ignored (no state change, no ack).
- Requester must drop req by the cycle after its ack; a req still high in IDLE is treated as a new byte.
- Reset asserted in any state: next edge forces the reset values; any in-flight ack is lost.

## Timing
- req sampled high at edge k (state IDLE): edge k sets selection and enters START; tx_start high cycle k→k+1; busy high from edge k.
- tx_done_tick high at edge m (WAIT): ack high cycle m→m+1; IDLE at edge m+1.
- Back-to-back: with another req pending, next tx_start is 2 cycles after the ack cycle (ACK→IDLE→START).
- Request-to-start latency: 1 cycle after the sampling edge; multiplexor output is valid in the same cycle tx_start is high.
- All outputs are registered or pure state decodes; no combinational path from req or tx_done_tick to any output.

## Configuration
- ARB_TIMEOUT_EN defined: watchdog counter clears on entering WAIT and increments each WAIT cycle; when it reaches TO_CYCLES−1 without tx_done_tick, timeout_err pulses one cycle and FSM → ACK (ack issues normally, pointer advances). tx_done_tick in the same cycle as expiry wins: normal ACK, no timeout_err.
- ARB_TIMEOUT_EN undefined: no counter; WAIT holds indefinitely; timeout_err tied 0.

## Test plan
- Reset: drive reset 3 cycles with req=2'b11 → selection=0, tx_start=0, ack=0, busy=0 throughout; first grant after release goes to requester 0.
- Single request: req=2'b10, tx_done_tick 10 cycles after tx_start → selection=1, one tx_start pulse, ack=2'b10 one cycle after the done tick, busy low afterward.
- Fairness: req=2'b11 held, requesters drop req on their ack and re-raise 1 cycle later → grants alternate 0,1,0,1; tx_start pulses spaced (done delay + 3) cycles.
- Spurious/late events: tx_done_tick in IDLE and req dropped during WAIT → no ack from the idle tick; in-flight transfer still acks.
- Mid-operation reset: reset in WAIT → IDLE next edge, no ack, pointer=0, selection=0.
- With ARB_TIMEOUT_EN, TO_CYCLES=16, no tx_done_tick → timeout_err and ack pulse together 16 cycles after entering WAIT; with done tick at cycle 15 → ack only.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin owner of the shared UART transmitter.
// Picks a requester, drives the I/O multiplexor select, strobes tx_start,
// waits for tx_done_tick, then pulses ack to the granted requester.
// Optional feature macro: ARB_TIMEOUT_EN (WAIT-state watchdog with timeout_err).
module uart_tx_arbiter #(
    parameter int unsigned R         = 2,
    parameter int unsigned T         = 8,
    parameter int unsigned N         = 1,
    parameter int unsigned TO_CYCLES = 4096
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [R-1:0] req,
    input  logic         tx_done_tick,
    output logic [N-1:0] selection,
    output logic         tx_start,
    output logic [R-1:0] ack,
    output logic         busy,
    output logic         timeout_err
);

    // Elaboration-time parameter sanity checks
    if (R < 2) begin : g_bad_r
        $error("uart_tx_arbiter: R must be at least 2");
    end
    if (N < $clog2(R)) begin : g_bad_n
        $error("uart_tx_arbiter: N too narrow for R");
    end
    if (T < 1) begin : g_bad_t
        $error("uart_tx_arbiter: T must be at least 1");
    end
    if (TO_CYCLES < 2) begin : g_bad_to
        $error("uart_tx_arbiter: TO_CYCLES must be at least 2");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [N-1:0]   ptr_q, ptr_d;
    logic [N-1:0]   sel_q, sel_d;
    logic           tx_start_q, tx_start_d;
    logic [R-1:0]   ack_q, ack_d;
    logic           busy_q, busy_d;
    logic           tout_q, tout_d;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned WDW = (TO_CYCLES > 2) ? $clog2(TO_CYCLES) : 1;
    logic [WDW-1:0] wdog_q, wdog_d;
`endif

    logic [R-1:0]   rot;
    logic [N:0]     sum;
    logic           pick_found;
    logic [N-1:0]   pick_idx;

    // Round-robin pick: rotate req so the pointer sits at bit 0, take the
    // first set bit, then map the offset back to an absolute index mod R.
    always_comb begin
        rot        = R'({req, req} >> ptr_q);
        sum        = '0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int unsigned i = 0; i < R; i++) begin
            if (!pick_found && rot[i]) begin
                pick_found = 1'b1;
                sum        = {1'b0, ptr_q} + (N+1)'(i);
                if (sum >= (N+1)'(R)) begin
                    sum = sum - (N+1)'(R);
                end
                pick_idx = sum[N-1:0];
            end
        end
    end

    // Next-state and next-output computation; outputs are registered so
    // tx_start/ack/timeout_err appear exactly in the START/ACK state cycles.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        sel_d      = sel_q;
        tx_start_d = 1'b0;
        ack_d      = '0;
        busy_d     = busy_q;
        tout_d     = 1'b0;
`ifdef ARB_TIMEOUT_EN
        wdog_d     = wdog_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    grant_d    = pick_idx;
                    sel_d      = pick_idx;
                    tx_start_d = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = S_START;
                end
            end
            S_START: begin
                state_d = S_WAIT;
`ifdef ARB_TIMEOUT_EN
                wdog_d  = '0;
`endif
            end
            S_WAIT: begin
                if (tx_done_tick) begin
                    state_d = S_ACK;
                    for (int unsigned i = 0; i < R; i++) begin
                        ack_d[i] = (grant_q == N'(i));
                    end
`ifdef ARB_TIMEOUT_EN
                end else if (wdog_q == WDW'(TO_CYCLES - 1)) begin
                    state_d = S_ACK;
                    tout_d  = 1'b1;
                    for (int unsigned i = 0; i < R; i++) begin
                        ack_d[i] = (grant_q == N'(i));
                    end
                end else begin
                    wdog_d = wdog_q + 1'b1;
`endif
                end
            end
            S_ACK: begin
                ptr_d   = (grant_q == N'(R - 1)) ? '0 : grant_q + 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            ptr_q      <= '0;
            sel_q      <= '0;
            tx_start_q <= 1'b0;
            ack_q      <= '0;
            busy_q     <= 1'b0;
            tout_q     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            wdog_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            sel_q      <= sel_d;
            tx_start_q <= tx_start_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            tout_q     <= tout_d;
`ifdef ARB_TIMEOUT_EN
            wdog_q     <= wdog_d;
`endif
        end
    end

    assign selection = sel_q;
    assign tx_start  = tx_start_q;
    assign ack       = ack_q;
    assign busy      = busy_q;
`ifdef ARB_TIMEOUT_EN
    assign timeout_err = tout_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter (R=2, N=1). Inputs are driven and
// outputs sampled on the falling clock edge; the DUT acts on rising edges.
module tb_uart_tx_arbiter;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TB_TO = 16;
`else
    localparam int unsigned TB_TO = 4096;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req;
    logic       tx_done_tick;
    logic [0:0] selection;
    logic       tx_start;
    logic [1:0] ack;
    logic       busy;
    logic       timeout_err;

    int n_assert = 0;
    int n_fail   = 0;

    uart_tx_arbiter #(
        .R(2),
        .T(8),
        .N(1),
        .TO_CYCLES(TB_TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .tx_done_tick(tx_done_tick),
        .selection(selection),
        .tx_start(tx_start),
        .ack(ack),
        .busy(busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        logic [1:0] exp_sel;
        reset        = 1'b1;
        req          = 2'b11;
        tx_done_tick = 1'b0;

        // Reset held 3 cycles with both requests raised: outputs stay idle
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_sel",   32'(selection),   32'd0);
            chk("rst_start", 32'(tx_start),    32'd0);
            chk("rst_ack",   32'(ack),         32'd0);
            chk("rst_busy",  32'(busy),        32'd0);
            chk("rst_tout",  32'(timeout_err), 32'd0);
        end
        reset = 1'b0;

        // First grant after reset goes to requester 0
        step();
        chk("first_start", 32'(tx_start),  32'd1);
        chk("first_sel",   32'(selection), 32'd0);
        chk("first_busy",  32'(busy),      32'd1);
        req = 2'b00;
        step();
        chk("first_start_off", 32'(tx_start), 32'd0);
        chk("first_wait_busy", 32'(busy),     32'd1);
        tx_done_tick = 1'b1;
        step();
        chk("first_ack", 32'(ack), 32'd1);
        tx_done_tick = 1'b0;
        step();
        chk("first_ack_off", 32'(ack),  32'd0);
        chk("first_idle",    32'(busy), 32'd0);

        // Single request from requester 1, done tick 10 cycles after tx_start
        req = 2'b10;
        step();
        chk("single_start", 32'(tx_start),  32'd1);
        chk("single_sel",   32'(selection), 32'd1);
        for (int i = 1; i <= 9; i++) begin
            step();
            chk("single_wait_start", 32'(tx_start),  32'd0);
            chk("single_wait_ack",   32'(ack),       32'd0);
            chk("single_wait_sel",   32'(selection), 32'd1);
        end
        tx_done_tick = 1'b1;
        step();
        chk("single_ack", 32'(ack), 32'd2);
        tx_done_tick = 1'b0;
        req = 2'b00;
        step();
        chk("single_ack_off", 32'(ack),  32'd0);
        chk("single_idle",    32'(busy), 32'd0);

        // Fairness: both requesting; each drops on its ack and re-raises a cycle later.
        // Grants must alternate 0,1,0,1 with tx_start every 5 cycles
        // (START, WAIT, WAIT+tick, ACK, IDLE).
        req = 2'b11;
        step();
        for (int it = 0; it < 4; it++) begin
            exp_sel = (it % 2 == 0) ? 2'd0 : 2'd1;
            chk("fair_start", 32'(tx_start),  32'd1);
            chk("fair_sel",   32'(selection), 32'(exp_sel));
            step();
            chk("fair_start_off", 32'(tx_start), 32'd0);
            step();
            tx_done_tick = 1'b1;
            step();
            chk("fair_ack", 32'(ack), (exp_sel == 2'd0) ? 32'd1 : 32'd2);
            tx_done_tick = 1'b0;
            req[exp_sel[0]] = 1'b0;
            if (it == 3) req = 2'b00;
            step();
            chk("fair_ack_off", 32'(ack), 32'd0);
            if (it != 3) req[exp_sel[0]] = 1'b1;
            step();
        end
        chk("fair_end_start", 32'(tx_start), 32'd0);
        chk("fair_end_busy",  32'(busy),     32'd0);

        // Spurious done ticks in IDLE, START and ACK; req dropped during the transfer
        tx_done_tick = 1'b1;
        step();
        chk("spur_idle_ack",   32'(ack),      32'd0);
        chk("spur_idle_busy",  32'(busy),     32'd0);
        chk("spur_idle_start", 32'(tx_start), 32'd0);
        tx_done_tick = 1'b0;
        req = 2'b01;
        step();
        chk("spur_start", 32'(tx_start),  32'd1);
        chk("spur_sel",   32'(selection), 32'd0);
        tx_done_tick = 1'b1;
        req = 2'b00;
        step();
        chk("spur_start_tick_ack", 32'(ack),  32'd0);
        chk("spur_start_tick_bsy", 32'(busy), 32'd1);
        tx_done_tick = 1'b0;
        step();
        chk("spur_wait_ack", 32'(ack), 32'd0);
        tx_done_tick = 1'b1;
        step();
        chk("late_ack", 32'(ack), 32'd1);
        step();
        chk("spur_ack_tick_ack",  32'(ack),      32'd0);
        chk("spur_ack_tick_busy", 32'(busy),     32'd0);
        tx_done_tick = 1'b0;
        step();
        chk("spur_after_start", 32'(tx_start), 32'd0);

        // Reset during WAIT: no ack, selection and pointer return to 0
        req = 2'b10;
        step();
        chk("mrst_start", 32'(tx_start),  32'd1);
        chk("mrst_sel",   32'(selection), 32'd1);
        step();
        reset        = 1'b1;
        tx_done_tick = 1'b1;
        step();
        chk("mrst_sel0", 32'(selection), 32'd0);
        chk("mrst_busy", 32'(busy),      32'd0);
        chk("mrst_ack",  32'(ack),       32'd0);
        reset        = 1'b0;
        tx_done_tick = 1'b0;
        req          = 2'b11;
        step();
        chk("mrst_ptr_start", 32'(tx_start),  32'd1);
        chk("mrst_ptr_sel",   32'(selection), 32'd0);
        req = 2'b00;

`ifdef ARB_TIMEOUT_EN
        // Watchdog expiry: timeout_err and ack together 16 cycles after entering WAIT
        step();
        for (int i = 1; i <= 15; i++) begin
            step();
            chk("to_wait_tout", 32'(timeout_err), 32'd0);
            chk("to_wait_ack",  32'(ack),         32'd0);
        end
        step();
        chk("to_tout", 32'(timeout_err), 32'd1);
        chk("to_ack",  32'(ack),         32'd1);
        step();
        chk("to_tout_off", 32'(timeout_err), 32'd0);
        // Done tick coinciding with expiry wins: ack without timeout_err
        req = 2'b10;
        step();
        chk("to2_start", 32'(tx_start), 32'd1);
        req = 2'b00;
        step();
        for (int i = 1; i <= 15; i++) begin
            step();
        end
        tx_done_tick = 1'b1;
        step();
        chk("to2_ack",  32'(ack),         32'd2);
        chk("to2_tout", 32'(timeout_err), 32'd0);
        tx_done_tick = 1'b0;
        step();
`else
        // Without the watchdog, WAIT holds with no timeout for a long stretch
        step();
        for (int i = 1; i <= 40; i++) begin
            step();
        end
        chk("nowd_busy", 32'(busy),        32'd1);
        chk("nowd_ack",  32'(ack),         32'd0);
        chk("nowd_tout", 32'(timeout_err), 32'd0);
        tx_done_tick = 1'b1;
        step();
        chk("nowd_ack_done", 32'(ack), 32'd1);
        tx_done_tick = 1'b0;
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
